// File: rtl/sync_filter_bank_pkg.sv
// Shared defaults and per-channel state encoding for the synchronizing glitch-filter bank.
// Pure declarations: no logic, no latency, no flow control.
package sync_filter_bank_pkg;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 3;

  // Sliced down to CHANNELS bits by the top level.
  localparam logic [31:0] DEF_RESET_VALUE = '1;
  localparam logic [31:0] DEF_FAST_SET    = '0;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_t;

  function automatic int count_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: SYNC_STAGES synchronizer, FILTER_CYCLES qualification counter, registered edge pulses.
// Latency SYNC_STAGES+FILTER_CYCLES (SYNC_STAGES+1 on a fast rise); no backpressure, hold freezes the output.
module sync_filter_channel
  import sync_filter_bank_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic RESET_VALUE   = 1'b1,
  parameter logic FAST_SET      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic signal_in,
  input  logic hold,
  output logic signal_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int            CW   = count_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  chan_state_t            state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   out_d, rise_d, fall_d;
  logic                   fire;

  assign sample = sync_q[SYNC_STAGES-1];

  // A fast-set rise commits immediately; everything else waits for the full window.
  assign fire = (FAST_SET && sample) || (count_q == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{RESET_VALUE}};
      state_q    <= STABLE;
      count_q    <= '0;
      signal_out <= RESET_VALUE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_in};
      state_q    <= state_d;
      count_q    <= count_d;
      signal_out <= out_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = signal_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (hold) begin
      state_d = STABLE;
      count_d = '0;
    end else begin
      case (state_q)
        STABLE: begin
          count_d = '0;
          if (sample != signal_out) begin
            if (fire) begin
              out_d  = sample;
              rise_d = sample;
              fall_d = !sample;
            end else begin
              state_d = PENDING;
              count_d = count_q + CW'(1);
            end
          end
        end
        PENDING: begin
          if (sample == signal_out) begin
            state_d = STABLE;
            count_d = '0;
          end else if (fire) begin
            state_d = STABLE;
            count_d = '0;
            out_d   = sample;
            rise_d  = sample;
            fall_d  = !sample;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          state_d = STABLE;
          count_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronizing glitch filters with per-channel edge pulses and a combined change flag.
// Latency SYNC_STAGES+FILTER_CYCLES per channel; no backpressure, hold freezes all outputs.
module sync_filter_bank
  import sync_filter_bank_pkg::*;
#(
  parameter int                  CHANNELS      = DEF_CHANNELS,
  parameter int                  SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int                  FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = DEF_RESET_VALUE[CHANNELS-1:0],
  parameter logic [CHANNELS-1:0] FAST_SET      = DEF_FAST_SET[CHANNELS-1:0]
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic                hold,
  output logic [CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filter_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i]),
      .FAST_SET      (FAST_SET[i])
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .signal_in  (signal_in[i]),
      .hold       (hold),
      .signal_out (signal_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: doc/sync_filter_bank.md
SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, >=2.
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: consecutive differing samples required to change output, >=1.
REQ-004 SHALL have parameter RESET_VALUE, CHANNELS bits, default all-ones: per-channel reset level.
REQ-005 SHALL have parameter FAST_SET, CHANNELS bits, default all-zero: per-channel bit, 1 = rising transitions bypass the filter.
REQ-006 SHALL have port clock, input, 1: single clock for the whole block.
REQ-007 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port signal_in, input, CHANNELS: asynchronous raw inputs.
REQ-009 SHALL have port hold, input, 1: freeze filtered outputs.
REQ-010 SHALL have port signal_out, output, CHANNELS: synchronized, filtered levels.
REQ-011 SHALL have port rise_pulse, output, CHANNELS: one-cycle pulse on each 0->1 change of signal_out.
REQ-012 SHALL have port fall_pulse, output, CHANNELS: one-cycle pulse on each 1->0 change of signal_out.
REQ-013 SHALL have port any_change, output, 1: OR of rise_pulse and fall_pulse.

Function
REQ-014 Each channel SHALL pass signal_in through a SYNC_STAGES flop chain; its last stage is the sample s.
REQ-015 Each channel SHALL keep a counter of width clog2(FILTER_CYCLES+1) and a registered level signal_out.
REQ-016 Channel states: STABLE (s==out, count=0) and PENDING (s!=out, count>0).
REQ-017 If s==out, count SHALL clear to 0 on the next edge, returning to STABLE; a glitch shorter than FILTER_CYCLES samples SHALL never reach signal_out.
REQ-018 If s!=out and count==FILTER_CYCLES-1, then on that edge signal_out<=s, count<=0, and the matching pulse SHALL assert for exactly one cycle; otherwise count increments.
REQ-019 Latency: an input change that settles before edge 1 SHALL appear on signal_out after edge SYNC_STAGES+FILTER_CYCLES.
REQ-020 If the FAST_SET bit is 1, and s==1 while out==0, then out<=1 on the next edge, count clears and rise_pulse asserts; latency SYNC_STAGES+1. Falling transitions remain filtered.
REQ-021 FILTER_CYCLES=1 SHALL give an unfiltered synchronizer with latency SYNC_STAGES+1.
REQ-022 While hold=1, the synchronizer chains SHALL run, and signal_out SHALL be frozen, counters held at 0, and pulses 0. After release, filtering SHALL restart from count 0.
REQ-023 The counter SHALL never exceed FILTER_CYCLES-1 and SHALL never wrap.
REQ-024 Pulses SHALL be registered, coincident with the first cycle of the new signal_out value; rise_pulse and fall_pulse of one channel SHALL never both be 1.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-026 On any clock edge with reset=1, the sync stages and signal_out SHALL load RESET_VALUE, and counters, rise_pulse, fall_pulse and any_change SHALL load 0.
REQ-027 Reset SHALL take priority over hold and any pending count; a mid-count reset SHALL discard the pending transition without emitting a pulse.
REQ-028 Reset deassertion SHALL NOT produce a pulse, even if signal_in differs from RESET_VALUE; a later change follows REQ-019/020.

Structure
REQ-029 A shared package SHALL hold the default parameter values and the channel-state encoding (STABLE, PENDING).
REQ-030 The per-channel logic SHALL be one sub-module, sync_filter_channel, instantiated CHANNELS times by a generate loop; the top level only does the OR for any_change.

Verification (CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3, RESET_VALUE=4'b0001, FAST_SET=4'b0010)
REQ-031 Reset for 3 cycles with signal_in=4'b0000 -> signal_out=4'b0001, all pulses 0 during reset and after deassertion until edge 5.
REQ-032 ch2 raised and held -> signal_out[2]=1 after edge 5, rise_pulse[2]=1 for exactly that one cycle, any_change=1.
REQ-033 ch0 low for 2 cycles then high again -> signal_out[0] stays 1, no fall_pulse[0].
REQ-034 ch1 (fast) raised -> signal_out[1]=1 after edge 3; later lowered -> signal_out[1]=0 after edge 5.
REQ-035 ch3 raised, reset asserted at edge 4 -> no rise_pulse[3], signal_out[3]=0; after reset, ch3 still high -> rises 5 edges later.
REQ-036 hold=1 while ch0 falls for 10 cycles -> signal_out[0] stays 1; hold released -> signal_out[0]=0 after edge 3 post-release.
